// File: rtl/core_run_pkg.sv
// core_run_pkg: shared types and constants for the core run/halt/step sequencer.
// Optional retire counter is enabled by CORE_RUN_CTRL_RETIRE_CNT_EN.
package core_run_pkg;

    typedef enum logic [1:0] {
        ST_HALTED   = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } run_state_t;

    typedef enum logic [1:0] {
        OP_HALT = 2'b00,
        OP_RUN  = 2'b01,
        OP_STEP = 2'b10,
        OP_CLR  = 2'b11
    } cmd_op_t;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_RESET   = 3'd1,
        CAUSE_HOST    = 3'd2,
        CAUSE_BP      = 3'd3,
        CAUSE_STEP    = 3'd4,
        CAUSE_ILLEGAL = 3'd5
    } halt_cause_t;

    // aluctl code the decoder emits for an unrecognised instruction
    localparam logic [5:0] ALU_ERR = 6'b111111;

    function automatic logic is_alu_err(input logic [5:0] aluctl);
        return aluctl == ALU_ERR;
    endfunction

endpackage

// File: rtl/core_bp_match.sv
// core_bp_match: PC breakpoint comparator with a one-shot skip so that
// resuming from a breakpoint PC executes that instruction once.
module core_bp_match
    import core_run_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bp_en,
    input  logic [XLEN-1:0] bp_addr,
    input  logic [XLEN-1:0] pc,
    input  logic            skip_set,
    input  logic            retire,
    output logic            skip_bp,
    output logic            bp_hit
);

    logic addr_eq;

    assign addr_eq = (pc == bp_addr);
    assign bp_hit  = bp_en & addr_eq & ~skip_bp;

    // a resume command outranks the retire happening in its accept cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_bp <= 1'b0;
        end else if (skip_set) begin
            skip_bp <= 1'b1;
        end else if (retire) begin
            skip_bp <= 1'b0;
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run/halt/single-step sequencer driving the core retire enable.
// Define CORE_RUN_CTRL_RETIRE_CNT_EN to build the retired-instruction counter.
module core_run_ctrl
    import core_run_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int STEP_W   = 16,
    parameter bit BOOT_RUN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic              bp_en,
    input  logic [XLEN-1:0]   bp_addr,
    input  logic [XLEN-1:0]   pc,
    input  logic              illegal_instr,
    output logic              core_en,
    output logic              halted,
    output logic [2:0]        halt_cause,
    output logic [STEP_W-1:0] steps_left,
    output logic              cmd_ack,
    output logic [31:0]       retired_cnt
);

    localparam run_state_t BOOT_STATE =
        BOOT_RUN ? ST_RUNNING : ST_HALTED;
    localparam halt_cause_t BOOT_CAUSE =
        BOOT_RUN ? CAUSE_NONE : CAUSE_RESET;
    localparam logic [STEP_W-1:0] STEP_ONE =
        {{(STEP_W-1){1'b0}}, 1'b1};

    run_state_t        state;
    run_state_t        state_nx;
    halt_cause_t       cause;
    halt_cause_t       cause_nx;
    logic [STEP_W-1:0] steps;
    logic [STEP_W-1:0] steps_nx;
    logic [STEP_W-1:0] step_load;
    logic              ack;
    logic              accept;
    logic              active;
    logic              stop;
    logic              retire;
    logic              last_step;
    logic              skip_set;
    logic              skip_bp;
    logic              bp_hit;
    logic              op_halt;
    logic              op_run;
    logic              op_step;
    logic              op_clr;

    assign op_halt = (cmd_op == OP_HALT);
    assign op_run  = (cmd_op == OP_RUN);
    assign op_step = (cmd_op == OP_STEP);
    assign op_clr  = (cmd_op == OP_CLR);

    assign cmd_ready = ~ack;
    assign accept    = cmd_valid & cmd_ready;
    assign skip_set  = accept & (op_run | op_step);

    assign active    = (state != ST_HALTED);
    assign stop      = illegal_instr | bp_hit;
    assign retire    = active & ~stop;
    // a cleared counter while stepping still finishes on the next retire
    assign last_step = (state == ST_STEPPING) & (steps <= STEP_ONE);
    assign step_load = (cmd_arg == '0) ? STEP_ONE : cmd_arg;

    core_bp_match #(
        .XLEN (XLEN)
    ) u_bp (
        .clk      (clk),
        .rst_n    (rst_n),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .pc       (pc),
        .skip_set (skip_set),
        .retire   (retire),
        .skip_bp  (skip_bp),
        .bp_hit   (bp_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT_STATE;
        end else begin
            state <= state_nx;
        end
    end

    // an accepted command overrides any stop seen in its accept cycle
    always_comb begin
        state_nx = state;
        if (active & stop) begin
            state_nx = ST_HALTED;
        end else if (retire & last_step) begin
            state_nx = ST_HALTED;
        end
        if (accept) begin
            unique case (1'b1)
                op_halt: state_nx = ST_HALTED;
                op_run:  state_nx = ST_RUNNING;
                op_step: state_nx = ST_STEPPING;
                op_clr:  state_nx = state_nx;
            endcase
        end
    end

    always_comb begin
        core_en = rst_n & retire;
        halted  = (state == ST_HALTED);
    end

    always_comb begin
        cause_nx = cause;
        steps_nx = steps;
        if (active & stop) begin
            cause_nx = illegal_instr ? CAUSE_ILLEGAL : CAUSE_BP;
        end else if (retire & (state == ST_STEPPING)) begin
            if (last_step) begin
                cause_nx = CAUSE_STEP;
                steps_nx = '0;
            end else begin
                steps_nx = steps - STEP_ONE;
            end
        end
        if (accept) begin
            unique case (1'b1)
                op_halt: begin
                    cause_nx = CAUSE_HOST;
                end
                op_run: begin
                    cause_nx = CAUSE_NONE;
                end
                op_step: begin
                    cause_nx = CAUSE_NONE;
                    steps_nx = step_load;
                end
                op_clr: begin
                    cause_nx = CAUSE_NONE;
                    steps_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause <= BOOT_CAUSE;
            steps <= '0;
            ack   <= 1'b0;
        end else begin
            cause <= cause_nx;
            steps <= steps_nx;
            ack   <= accept;
        end
    end

    assign halt_cause = cause;
    assign steps_left = steps;
    assign cmd_ack    = ack;

`ifdef CORE_RUN_CTRL_RETIRE_CNT_EN
    logic [31:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept & op_clr) begin
            cnt <= '0;
        end else if (retire) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign retired_cnt = cnt;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed vector table, reset corner case and random
// stimulus checked against a behavioural model of the run controller.
module tb_core_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_arg = 16'd0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        illegal_instr = 1'b0;
    logic        core_en;
    logic        halted;
    logic [2:0]  halt_cause;
    logic [15:0] steps_left;
    logic        cmd_ack;
    logic [31:0] retired_cnt;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    core_run_ctrl #(
        .XLEN     (32),
        .STEP_W   (16),
        .BOOT_RUN (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_arg       (cmd_arg),
        .bp_en         (bp_en),
        .bp_addr       (bp_addr),
        .pc            (pc),
        .illegal_instr (illegal_instr),
        .core_en       (core_en),
        .halted        (halted),
        .halt_cause    (halt_cause),
        .steps_left    (steps_left),
        .cmd_ack       (cmd_ack),
        .retired_cnt   (retired_cnt)
    );

    // behavioural model: mode 0 halted, 1 free running, 2 counting steps
    int          m_mode;
    int          m_cause;
    int          m_steps;
    bit          m_skip;
    bit          m_ack;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_mode  = 1;
        m_cause = 0;
        m_steps = 0;
        m_skip  = 0;
        m_ack   = 0;
        m_cnt   = 0;
    endtask

    function automatic bit m_en();
        bit bp;
        bp = bp_en && (pc == bp_addr) && !m_skip;
        return rst_n && (m_mode != 0) && !illegal_instr && !bp;
    endfunction

    task automatic model_tick();
        bit en;
        bit acc;
        int nm;
        int nc;
        int ns;
        bit nk;
        logic [31:0] nn;
        en  = m_en();
        acc = cmd_valid && !m_ack;
        nm  = m_mode;
        nc  = m_cause;
        ns  = m_steps;
        nk  = m_skip;
        nn  = en ? m_cnt + 1 : m_cnt;
        if (m_mode != 0 && !en) begin
            nm = 0;
            nc = illegal_instr ? 5 : 3;
        end
        if (en) begin
            nk = 0;
            if (m_mode == 2) begin
                if (m_steps <= 1) begin
                    nm = 0;
                    nc = 4;
                    ns = 0;
                end else begin
                    ns = m_steps - 1;
                end
            end
        end
        if (acc) begin
            case (cmd_op)
                2'd0: begin nm = 0; nc = 2; end
                2'd1: begin nm = 1; nc = 0; nk = 1; end
                2'd2: begin
                    nm = 2; nc = 0; nk = 1;
                    ns = (cmd_arg == 0) ? 1 : int'(cmd_arg);
                end
                default: begin nc = 0; ns = 0; nn = 0; end
            endcase
        end
        m_mode  = nm;
        m_cause = nc;
        m_steps = ns;
        m_skip  = nk;
        m_ack   = acc;
        m_cnt   = nn;
    endtask

    function automatic logic [63:0] m_out();
        logic [31:0] cnt;
`ifdef CORE_RUN_CTRL_RETIRE_CNT_EN
        cnt = m_cnt;
`else
        cnt = 32'd0;
`endif
        return {m_en(), !m_ack, (m_mode == 0), 3'(m_cause),
                16'(m_steps), m_ack, cnt};
    endfunction

    function automatic logic [63:0] dut_out();
        return {core_en, cmd_ready, halted, halt_cause,
                steps_left, cmd_ack, retired_cnt};
    endfunction

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic drive(input logic v, input logic [1:0] op,
                         input logic [15:0] arg, input logic be,
                         input logic [31:0] ba, input logic [31:0] p,
                         input logic ill);
        cmd_valid     = v;
        cmd_op        = op;
        cmd_arg       = arg;
        bp_en         = be;
        bp_addr       = ba;
        pc            = p;
        illegal_instr = ill;
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst_n) model_tick();
        #1;
    endtask

    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic [15:0] arg;
        logic        be;
        logic [31:0] pc;
        logic        ill;
        logic        en;
        logic        h;
        logic [2:0]  c;
        logic [15:0] s;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [1:0] op, logic [15:0] arg,
                                logic be, logic [31:0] p, logic ill,
                                logic en, logic h, logic [2:0] c,
                                logic [15:0] s);
        vec_t r;
        r.v = v; r.op = op; r.arg = arg; r.be = be; r.pc = p;
        r.ill = ill; r.en = en; r.h = h; r.c = c; r.s = s;
        return r;
    endfunction

    initial begin
        //            v op arg be pc    ill en h c s
        tbl.push_back(mk(0, 0, 0,  1, 'h00, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  1, 'h04, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  1, 'h08, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  1, 'h0c, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  1, 'h10, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0,  1, 'h10, 0, 0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0,  1, 'h10, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  1, 'h14, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  1, 'h10, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 3,  1, 'h10, 0, 0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0,  1, 'h10, 0, 1, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0,  1, 'h14, 0, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0,  1, 'h18, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0,  1, 'h1c, 0, 0, 1, 4, 0));
        tbl.push_back(mk(1, 2, 0,  1, 'h1c, 0, 0, 1, 4, 0));
        tbl.push_back(mk(0, 0, 0,  1, 'h1c, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0,  1, 'h20, 0, 0, 1, 4, 0));
        tbl.push_back(mk(1, 2, 10, 0, 'h20, 0, 0, 1, 4, 0));
        tbl.push_back(mk(0, 0, 0,  0, 'h20, 0, 1, 0, 0, 10));
        tbl.push_back(mk(0, 0, 0,  0, 'h24, 0, 1, 0, 0, 9));
        tbl.push_back(mk(0, 0, 0,  0, 'h28, 0, 1, 0, 0, 8));
        tbl.push_back(mk(0, 0, 0,  0, 'h2c, 1, 0, 0, 0, 7));
        tbl.push_back(mk(1, 1, 0,  0, 'h2c, 1, 0, 1, 5, 7));
        tbl.push_back(mk(0, 0, 0,  0, 'h2c, 1, 0, 0, 0, 7));
        tbl.push_back(mk(0, 0, 0,  0, 'h2c, 0, 0, 1, 5, 7));
        tbl.push_back(mk(1, 3, 0,  0, 'h2c, 0, 0, 1, 5, 7));
        tbl.push_back(mk(0, 0, 0,  0, 'h2c, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0,  0, 'h30, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 'h34, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  0, 'h38, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,  0, 'h3c, 0, 0, 1, 2, 0));

        model_reset();
        @(negedge clk);
        check("in_reset", dut_out(), m_out());
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].op, tbl[i].arg, tbl[i].be,
                  32'h10, tbl[i].pc, tbl[i].ill);
            @(negedge clk);
            check($sformatf("tbl%0d_model", i), dut_out(), m_out());
            check($sformatf("tbl%0d", i),
                  {core_en, halted, halt_cause, steps_left},
                  {tbl[i].en, tbl[i].h, tbl[i].c, tbl[i].s});
            advance();
        end

        // reset landing in the middle of an 8-step run
        drive(1, 2'd2, 16'd8, 0, 0, 32'h40, 0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 32'h44 + 4 * i, 0);
            advance();
        end
        drive(0, 0, 0, 0, 0, 32'h50, 0);
        @(negedge clk);
        check("mid_step_left", {core_en, steps_left}, {1'b1, 16'd5});
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_core_en", {core_en, steps_left}, {1'b0, 16'd0});
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset", {halted, halt_cause, steps_left, cmd_ack},
              {1'b0, 3'd0, 16'd0, 1'b0});
        check("post_reset_model", dut_out(), m_out());
        advance();

        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 3) == 0, 2'($urandom % 4),
                  16'($urandom % 6), 1'($urandom % 2),
                  32'(4 * ($urandom % 4)), 32'(4 * ($urandom % 8)),
                  ($urandom % 12) == 0);
            @(negedge clk);
            check($sformatf("rand%0d", i), dut_out(), m_out());
            advance();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Run/halt/single-step sequencer for the single-cycle RV32I core's datapath (decoder, ALU, register file). It produces `core_en`, which gates PC update, register-file write and memory write. One cycle with `core_en=1` retires exactly one instruction. It is commanded from the logic-analyzer debug interface, halts on a PC breakpoint or on an illegal-instruction flag from the ALU decoder (aluctl error code), and reports halt cause and progress.

Parameters:
XLEN, 32, PC/breakpoint width
STEP_W, 16, width of step-count argument and counter
BOOT_RUN, 1, 1: leave reset in RUNNING; 0: leave reset in HALTED with cause RESET

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  host command ready
cmd_op  in  2  00 HALT, 01 RUN, 10 STEP, 11 CLR (clear cause/counters)
cmd_arg  in  STEP_W  step count for STEP
bp_en  in  1  breakpoint enable
bp_addr  in  XLEN  breakpoint PC
pc  in  XLEN  current core PC
illegal_instr  in  1  decoder error (aluctl all-ones) for instruction at pc
core_en  out  1  retire enable to PC/regfile/memory write
halted  out  1  state==HALTED
halt_cause  out  3  0 NONE,1 RESET,2 HOST,3 BP,4 STEP,5 ILLEGAL
steps_left  out  STEP_W  remaining steps
cmd_ack  out  1  one-cycle pulse the cycle after a command is accepted
retired_cnt  out  32  retired-instruction count (optional feature)

Behaviour:
- Reset (async assert, sync release):
  - state RUNNING if BOOT_RUN, else HALTED.
  - halt_cause NONE if BOOT_RUN, else RESET.
  - steps_left 0, cmd_ack 0, skip_bp 0, retired_cnt 0.
  - Reset mid-step aborts the step with no retire.
- Handshake:
  - cmd_ready=1 in every state except the cycle cmd_ack is high; that gives one command per two cycles.
  - A command is accepted on a rising edge with cmd_valid&cmd_ready.
  - A command takes effect from the next cycle. The instruction in the accept cycle retires or not per the current state.
- States:
  - HALTED: core_en=0.
  - RUNNING: core_en=1 unless a stop condition holds.
  - STEPPING: same as RUNNING, plus step counting.
- Stop condition (combinational, same cycle; core_en forced 0, instruction not retired):
  - illegal_instr=1 → next state HALTED, cause ILLEGAL.
  - else bp_en & pc==bp_addr & !skip_bp → HALTED, cause BP.
  - ILLEGAL has priority over BP.
- HALT: from any state → HALTED, cause HOST. In HALTED it is a no-op apart from cause=HOST.
- RUN: → RUNNING, cause NONE, skip_bp=1. skip_bp clears after the first retired cycle, so resuming at a breakpoint PC executes that instruction once.
- STEP:
  - → STEPPING with steps_left = (cmd_arg==0 ? 1 : cmd_arg), skip_bp=1.
  - Each retired cycle decrements steps_left.
  - The retire with steps_left==1 → HALTED, cause STEP, steps_left 0.
  - A BP/ILLEGAL stop during STEPPING halts with that cause and keeps the residual steps_left.
- CLR: cause NONE, steps_left 0, retired_cnt 0; state unchanged.
- A RUN or STEP accepted while RUNNING or STEPPING re-targets to the new state and count.
- Resuming with illegal_instr still high re-halts immediately with zero retires.

Optional Feature:
- Macro CORE_RUN_CTRL_RETIRE_CNT_EN.
- Defined: retired_cnt increments by 1 per core_en=1 cycle, wraps 0xFFFFFFFF→0, clears on reset/CLR.
- Undefined: no counter flops; retired_cnt tied 0.

Decomposition:
- Package core_run_pkg: state enum (HALTED, RUNNING, STEPPING), cmd_op enum, halt_cause enum, ALU_ERR constant 6'b111111.
- One sub-module, core_bp_match: XLEN compare, skip_bp flag, bp_hit output.

Test Plan:
- BOOT_RUN=1, release reset, pc advancing 0x0,0x4,... → core_en=1 from first cycle, halted=0, cause NONE, retired_cnt=5 after 5 cycles.
- RUNNING, bp_en=1, bp_addr=0x10, pc reaches 0x10 → core_en=0 that cycle, halted=1, cause=3. Then RUN → 0x10 retires once; if pc returns to 0x10 later, halts again.
- HALTED, STEP cmd_arg=3 → exactly 3 core_en pulses, then halted=1, cause=4, steps_left=0. STEP cmd_arg=0 → exactly 1 pulse.
- STEPPING cmd_arg=10, illegal_instr=1 on 4th instruction → 3 retires, halted, cause=5, steps_left=7. RUN with illegal_instr still 1 → 0 retires, cause=5.
- HALT accepted while RUNNING → instruction in accept cycle retires, core_en=0 next cycle, cause=2, cmd_ack pulses once, cmd_ready low for that cycle.
- rst_n asserted mid-STEP (steps_left=5) → core_en=0 asynchronously; after release steps_left=0 and state per BOOT_RUN.
